// File: rtl/alu_pkg.sv
// Shared ALU encodings and RV32I decode constants used by the issue stage
// and by anything downstream that consumes the ALU operation code.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 to operation for the non-alternate encodings shared by OP and OP-IMM
    function automatic alu_op_t base_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] i_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] u_imm(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of an instruction into ALU operation, operand
// pair and write-back enable; illegal encodings collapse to a harmless ADD 0,0.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output alu_op_t     alu_op,
    output logic        rd_we,
    output logic        illegal
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [31:0] shamt_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    alu_op_t     op_s;
    logic        bad_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign shamt_s  = {27'd0, instr[24:20]};

    // Field decode; every path that does not resolve to a legal op raises bad_s
    always_comb begin
        a_s   = 32'd0;
        b_s   = 32'd0;
        op_s  = ALU_ADD;
        bad_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                a_s = rs1_data;
                b_s = rs2_data;
                if (funct7_s == F7_BASE) begin
                    op_s = base_op(funct3_s);
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
                    op_s = ALU_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
                    op_s = ALU_SRA;
                end else begin
                    bad_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a_s = rs1_data;
                b_s = i_imm(instr);
                case (funct3_s)
                    3'b001: begin
                        b_s = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            op_s = ALU_SLL;
                        end else begin
                            bad_s = 1'b1;
                        end
                    end
                    3'b101: begin
                        b_s = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            op_s = ALU_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            op_s = ALU_SRA;
                        end else begin
                            bad_s = 1'b1;
                        end
                    end
                    default: op_s = base_op(funct3_s);
                endcase
            end
            OPC_LUI: begin
                a_s = 32'd0;
                b_s = u_imm(instr);
            end
            OPC_AUIPC: begin
                a_s = pc;
                b_s = u_imm(instr);
            end
            default: bad_s = 1'b1;
        endcase
    end

    assign illegal = bad_s;
    assign alu_a   = bad_s ? 32'd0 : a_s;
    assign alu_b   = bad_s ? 32'd0 : b_s;
    assign alu_op  = bad_s ? ALU_ADD : op_s;
    assign rd_we   = !bad_s && (rd_s != 5'd0);

endmodule

// File: rtl/alu_issue_decoder.sv
// Single-entry ID/EX issue register: decodes an RV32I word for the ALU and
// holds it under a valid/ready handshake with flush and delivery counters.
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    output logic [4:0]        rd,
    output logic              rd_we,
    output logic              illegal,
    output logic [CNT_W-1:0]  legal_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [31:0]      dec_a_s;
    logic [31:0]      dec_b_s;
    alu_op_t          dec_op_s;
    logic             dec_we_s;
    logic             dec_bad_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             handshake_s;

    logic             out_valid_r;
    logic [31:0]      alu_a_r;
    logic [31:0]      alu_b_r;
    logic [3:0]       alu_op_r;
    logic [4:0]       rd_r;
    logic             rd_we_r;
    logic             illegal_r;
    logic [CNT_W-1:0] legal_cnt_r;
    logic [CNT_W-1:0] illegal_cnt_r;

    alu_op_decode u_dec (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_a    (dec_a_s),
        .alu_b    (dec_b_s),
        .alu_op   (dec_op_s),
        .rd_we    (dec_we_s),
        .illegal  (dec_bad_s)
    );

    // Flush suppresses the accept even when the register has room
    assign in_ready_s  = !out_valid_r || out_ready;
    assign accept_s    = in_valid && in_ready_s && !flush;
    assign handshake_s = out_valid_r && out_ready;

    // Occupancy of the single issue slot
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Decoded payload, loaded only on accept so a stalled entry holds stable
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r   <= 32'd0;
            alu_b_r   <= 32'd0;
            alu_op_r  <= 4'd0;
            rd_r      <= 5'd0;
            rd_we_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            alu_a_r   <= dec_a_s;
            alu_b_r   <= dec_b_s;
            alu_op_r  <= dec_op_s;
            rd_r      <= instr[11:7];
            rd_we_r   <= dec_we_s;
            illegal_r <= dec_bad_s;
        end else begin
            alu_a_r   <= alu_a_r;
            alu_b_r   <= alu_b_r;
            alu_op_r  <= alu_op_r;
            rd_r      <= rd_r;
            rd_we_r   <= rd_we_r;
            illegal_r <= illegal_r;
        end
    end

    // Delivery counters; a handshake in a flush cycle still delivered the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            legal_cnt_r   <= {CNT_W{1'b0}};
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (handshake_s && illegal_r) begin
            illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (handshake_s) begin
            legal_cnt_r   <= legal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            legal_cnt_r   <= legal_cnt_r;
            illegal_cnt_r <= illegal_cnt_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign rd          = rd_r;
    assign rd_we       = rd_we_r;
    assign illegal     = illegal_r;
    assign legal_cnt   = legal_cnt_r;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: directed test-plan cases with
// hand-computed results, then randomized traffic against a reference decoder.
module tb_alu_issue_decoder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [15:0] legal_cnt;
    logic [15:0] illegal_cnt;

    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    logic [15:0] exp_legal = 16'd0;
    logic [15:0] exp_illegal = 16'd0;

    alu_issue_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd), .rd_we(rd_we),
        .illegal(illegal), .legal_cnt(legal_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference decoder written from the ISA rules: -1 marks an illegal encoding
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        int base[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        int op = -1;
        exp_t e;
        logic [6:0] opc = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        logic [11:0] imm12 = i[31:20];
        e.a = 32'd0;
        e.b = 32'd0;
        e.rd = i[11:7];
        if (opc == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00) op = base[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
        end else if (opc == 7'h13) begin
            e.a = r1;
            e.b = 32'($signed(imm12));
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(i[24:20]);
                if (f7 == 7'h00) op = base[f3];
                else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
            end else begin
                op = base[f3];
            end
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.a = (opc == 7'h17) ? p : 32'd0;
            e.b = i & 32'hFFFF_F000;
            op = 0;
        end
        e.ill = (op < 0);
        if (e.ill) begin
            e.a = 32'd0;
            e.b = 32'd0;
            e.op = 4'd0;
            e.we = 1'b0;
        end else begin
            e.op = 4'(op);
            e.we = (e.rd != 5'd0);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [4:0] r, input logic we, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = r; e.we = we; e.ill = ill;
        return e;
    endfunction

    // Offer one instruction until accepted; push its expectation at the accepting edge
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input exp_t e, input bit rr);
        bit acc = 1'b0;
        int n = 0;
        instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
        while (!acc && n < 50) begin
            if (rr) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready && !flush && !rst;
            @(posedge clk);
            if (acc) exp_q.push_back(e);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want accept of %h", i);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flush(input bit v, input logic [31:0] i);
        flush = 1'b1;
        in_valid = v;
        instr = i;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        int k = $urandom_range(0, 5);
        int f = $urandom_range(0, 3);
        logic [6:0] f7 = (f == 0) ? 7'h00 : (f == 1) ? 7'h20 : (f == 2) ? 7'(i[31:25]) : 7'h00;
        case (k)
            0: begin i[6:0] = 7'h33; i[31:25] = f7; end
            1: begin i[6:0] = 7'h13; i[31:25] = f7; end
            2: i[6:0] = 7'h37;
            3: i[6:0] = 7'h17;
            4: i[6:0] = 7'h13;
            default: ;
        endcase
        return i;
    endfunction

    // Monitor: checks the held entry every cycle and retires it on handshake or squash
    initial begin
        exp_t e;
        bit held;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                held = (exp_q.size() != 0);
                chk("out_valid", 32'(out_valid), 32'(held));
                chk("in_ready", 32'(in_ready), 32'(!held || out_ready));
                chk("legal_cnt", 32'(legal_cnt), 32'(exp_legal));
                chk("illegal_cnt", 32'(illegal_cnt), 32'(exp_illegal));
                if (held && out_valid) begin
                    e = exp_q[0];
                    chk("alu_a", alu_a, e.a);
                    chk("alu_b", alu_b, e.b);
                    chk("alu_op", 32'(alu_op), 32'(e.op));
                    chk("rd_we", 32'(rd_we), 32'(e.we));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    if (!e.ill) chk("rd", 32'(rd), 32'(e.rd));
                end
                if (rst) begin
                    exp_q.delete();
                    exp_legal = 16'd0;
                    exp_illegal = 16'd0;
                end else if (held && out_ready) begin
                    e = exp_q.pop_front();
                    if (e.ill) exp_illegal = exp_illegal + 16'd1;
                    else exp_legal = exp_legal + 16'd1;
                end else if (held && flush) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] ri, rp, r1, r2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_flags", {30'd0, rd_we, illegal}, 32'd0);
        chk("rst_cnts", {legal_cnt, illegal_cnt}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Directed test-plan encodings with hand-computed results
        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0), 1'b0);
        send(32'h40435293, 32'h0, 32'h8000_0000, 32'd9,
             mk(32'h8000_0000, 32'd4, 4'd7, 5'd5, 1'b1, 1'b0), 1'b0);
        send(32'hABCDE0B7, 32'h0, 32'h1234, 32'h5678,
             mk(32'd0, 32'hABCD_E000, 4'd0, 5'd1, 1'b1, 1'b0), 1'b0);
        send(32'h00001117, 32'h100, 32'h1, 32'h2,
             mk(32'h100, 32'h1000, 4'd0, 5'd2, 1'b1, 1'b0), 1'b0);
        send(32'h0000007F, 32'h0, 32'h11, 32'h22, mk(32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1), 1'b0);
        send(32'h022081B3, 32'h0, 32'h11, 32'h22, mk(32'd0, 32'd0, 4'd0, 5'd3, 1'b0, 1'b1), 1'b0);
        idle(3);
        chk("dir_legal_cnt", 32'(legal_cnt), 32'd4);
        chk("dir_illegal_cnt", 32'(illegal_cnt), 32'd2);

        // Stall with a waiting input, then back-to-back release, then flush with input
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd10, 32'd20, mk(32'd10, 32'd20, 4'd0, 5'd3, 1'b1, 1'b0), 1'b0);
        instr = 32'h40435293; rs1_data = 32'h44; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h40435293, 32'h0, 32'h44, 32'h0, mk(32'h44, 32'd4, 4'd7, 5'd5, 1'b1, 1'b0), 1'b0);
        pulse_flush(1'b1, 32'hABCDE0B7);
        idle(2);

        // Flush of a stalled entry is not counted; reset mid-operation discards and clears
        out_ready = 1'b0;
        send(32'h00001117, 32'h200, 32'h0, 32'h0, mk(32'h200, 32'h1000, 4'd0, 5'd2, 1'b1, 1'b0), 1'b0);
        pulse_flush(1'b0, 32'h0);
        send(32'h0000007F, 32'h0, 32'h0, 32'h0, mk(32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1), 1'b0);
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("midrst_cnts", {legal_cnt, illegal_cnt}, 32'd0);

        // Randomized traffic against the reference decoder
        for (int n = 0; n < 400; n++) begin
            ri = rand_instr(); rp = $urandom; r1 = $urandom; r2 = $urandom;
            send(ri, rp, r1, r2, ref_decode(ri, rp, r1, r2), 1'b1);
            if ($urandom_range(0, 15) == 0) begin
                out_ready = $urandom_range(0, 1);
                pulse_flush($urandom_range(0, 1), rand_instr());
            end
        end
        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_decoder.md
# alu_issue_decoder

- Single-entry ID/EX issue stage: decodes an RV32I instruction word into the 4-bit ALU operation code and its operand pair, and registers the result.
- Sits between the register-file read stage and the ALU; it is the producer of the operation encoding the ALU consumes.
- Uses a valid/ready handshake on both sides, supports flush and stall, flags illegal encodings, and keeps delivered-operation counters.

## Interface
- CNT_W, 16, width of the legal/illegal delivery counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read of rs1
- rs2_data  in  32  register-file read of rs2
- flush  in  1  squash held and incoming instruction
- out_valid  out  1  issued operation valid
- out_ready  in  1  ALU/EX stage accepts
- alu_a  out  32  operand A
- alu_b  out  32  operand B
- alu_op  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9
- rd  out  5  destination register
- rd_we  out  1  write-back enable
- illegal  out  1  issued entry was an illegal encoding
- legal_cnt  out  CNT_W  delivered legal operations
- illegal_cnt  out  CNT_W  delivered illegal operations

## Operation
- Decode fields: opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12], funct7=instr[31:25].
- Immediates:
  - I-imm is sign-extended instr[31:20].
  - U-imm is {instr[31:12], 12'b0}.
  - Shift immediates are {27'b0, instr[24:20]}.
- OP (0110011): A=rs1_data, B=rs2_data.
  - funct3 000 → ADD (funct7 0000000) or SUB (funct7 0100000).
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRL (0000000) or SRA (0100000).
  - 110 → OR; 111 → AND.
  - funct7 0100000 with any other funct3 → illegal.
  - funct7 not in {0000000, 0100000} → illegal.
- OP-IMM (0010011): A=rs1_data, B=I-imm.
  - Same funct3 map, except 000 is always ADD (no SUB).
  - 001 requires funct7=0000000; otherwise illegal.
  - 101 requires funct7 0000000 (SRL) or 0100000 (SRA); otherwise illegal.
  - Shifts use the shift immediate for B.
- LUI (0110111): A=0, B=U-imm, ADD.
- AUIPC (0010111): A=pc, B=U-imm, ADD.
- Any other opcode is illegal.
- Illegal entries:
  - Still flow through the handshake with illegal=1.
  - alu_op=ADD, alu_a=alu_b=0, rd_we=0.
- rd_we=1 for legal entries with rd≠0; rd_we=0 when rd=0.
- Counters increment on the output handshake (out_valid&out_ready):
  - legal_cnt when illegal=0; illegal_cnt when illegal=1.
  - Both wrap modulo 2^CNT_W.
  - Squashed entries are never counted.

## Timing
- Reset: out_valid=0, all data outputs 0, illegal=0, rd_we=0, both counters 0.
- in_ready=!out_valid | out_ready. This is combinational from out_ready. in_ready is 1 during reset-release idle.
- Accept occurs when in_valid&in_ready. Decoded outputs appear the next cycle (latency 1), all registered.
- Back-to-back:
  - Accept and output handshake in the same cycle replaces the entry.
  - out_valid stays 1; no bubble.
- Stall: while out_valid&!out_ready, every output holds stable and no input is taken.
- Flush:
  - Next cycle out_valid=0.
  - Any input offered in the flush cycle is dropped, even if in_ready=1.
  - Flush wins over accept.
  - A handshake occurring in the flush cycle still counts.
- rst asserted mid-operation discards the held entry and clears the counters on the next edge, regardless of flush or handshakes.

## Structure
- Shared package alu_pkg holds:
  - the alu_op_t 4-bit enum with the encodings above;
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- One natural sub-module: alu_op_decode, purely combinational. It maps instr, pc and register data to {alu_a, alu_b, alu_op, rd_we, illegal}.
- The top level holds the pipeline register, handshake logic and counters.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle:
  - alu_op=0, alu_a=5, alu_b=7, rd=3, rd_we=1;
  - legal_cnt=1 after handshake.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 → alu_op=7, alu_b=4, illegal=0.
- `lui x1,0xABCDE` (0xABCDE0B7) → alu_a=0, alu_b=0xABCDE000, alu_op=0.
- `auipc x2,0x1` (0x00001117) at pc=0x100 → alu_a=0x100, alu_b=0x1000, alu_op=0.
- Opcode 0x7F and OP with funct7=0000001:
  - illegal=1, rd_we=0, alu_op=0;
  - illegal_cnt=2, legal_cnt unchanged.
- Handshake and flush sequence:
  - out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0.
  - Then out_ready=1 with new input → back-to-back delivery, no bubble.
  - Then flush with in_valid=1 → out_valid=0 next cycle, input dropped.
